// File: rtl/ddr_app_responder.sv
// ddr_app_responder: MIG-style DDR app-interface responder backed by on-chip RAM.
// Latency: a read accepted at edge T raises app_rd_data_valid in cycle T+1+RD_LATENCY.
// Backpressure: app_rdy/app_wdf_rdy = calibrated & FIFO not full (registered occupancy); no read backpressure.
//
// Ports:
//   ddr_ui_clk, ddr_log_rst_n      : UI clock, async active-low reset
//   app_addr/app_cmd/app_en/app_rdy: command channel (burst index = app_addr[MEM_DEPTH_LOG2+2:3])
//   app_wdf_data/_wren/_end/_rdy   : write-data channel, one beat per burst
//   app_rd_data/app_rd_data_valid  : in-order read return, one strobe per read
//   init_calib_complete            : rises CALIB_CYCLES edges after reset release
//   o_proto_err                    : sticky; illegal command or app_wdf_wren != app_wdf_end
//
// Optional build macro: DDR_RESP_STALL_EN adds an LFSR that randomly drops both
// ready outputs (independently, ~1 in 8 cycles) to stress upstream handshakes.

// ddr_resp_fifo: small generic FIFO used for the command and write-data queues.
// Latency: pushed entry is visible at out_dat the cycle after the push edge.
// Backpressure: push ignored while full; full reflects registered occupancy only.
module ddr_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two so pointers wrap naturally
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             full,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push, pop;

  assign full    = (cnt_q == FULL_CNT);
  assign out_vld = (cnt_q != '0);
  assign out_dat = slot[rd_ptr_q];
  assign push    = in_vld & ~full;
  assign pop     = out_rdy & out_vld;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: a flush only has to clear the pointers.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr_q] <= in_dat;
  end
endmodule

module ddr_app_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 28,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 8,
  parameter int CALIB_CYCLES   = 100
) (
  input  logic                    ddr_ui_clk,
  input  logic                    ddr_log_rst_n,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH*8-1:0] app_wdf_data,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH*8-1:0] app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    init_calib_complete,
  output logic                    o_proto_err
);
  localparam int BW    = DATA_WIDTH * 8;
  localparam int IW    = MEM_DEPTH_LOG2;
  localparam int CW    = 3 + IW;
  localparam int CNT_W = $clog2(CALIB_CYCLES + 1);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // ---------------- calibration ----------------
  logic [CNT_W-1:0] calib_cnt_q, calib_cnt_d;
  logic             calib_q, calib_d;

  always_comb begin
    calib_cnt_d = calib_cnt_q;
    calib_d     = calib_q;
    if (!calib_q) begin
      calib_cnt_d = calib_cnt_q + CNT_W'(1);
      // Counter holds the number of edges already seen, so this edge is the CALIB_CYCLES-th.
      if (calib_cnt_q == CNT_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
    end
  end

  // ---------------- optional ready stalls ----------------
  logic stall_cmd, stall_wdf;
`ifdef DDR_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  // x^16 + x^14 + x^13 + x^11 + 1, maximal length.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
    if (!ddr_log_rst_n) lfsr_q <= 16'hACE1;
    else                lfsr_q <= lfsr_d;
  end
  // Disjoint 3-bit fields: each ready is dropped when its field is zero (~1/8).
  assign stall_cmd = (lfsr_q[2:0]  == 3'b000);
  assign stall_wdf = (lfsr_q[10:8] == 3'b000);
`else
  assign stall_cmd = 1'b0;
  assign stall_wdf = 1'b0;
`endif

  // ---------------- command and write-data queues ----------------
  logic          cmd_full, cmd_out_vld, cmd_pop;
  logic [CW-1:0] cmd_out_dat;
  logic          wdf_full, wdf_out_vld, wdf_pop;
  logic [BW-1:0] wdf_out_dat;

  assign app_rdy     = calib_q & ~cmd_full & ~stall_cmd;
  assign app_wdf_rdy = calib_q & ~wdf_full & ~stall_wdf;

  ddr_resp_fifo #(.WIDTH(CW), .DEPTH(4)) u_cmd_fifo (
    .clk     (ddr_ui_clk),
    .rst_n   (ddr_log_rst_n),
    .in_vld  (app_en & app_rdy),
    .in_dat  ({app_cmd, app_addr[IW+2:3]}),
    .full    (cmd_full),
    .out_vld (cmd_out_vld),
    .out_dat (cmd_out_dat),
    .out_rdy (cmd_pop)
  );

  ddr_resp_fifo #(.WIDTH(BW), .DEPTH(4)) u_wdf_fifo (
    .clk     (ddr_ui_clk),
    .rst_n   (ddr_log_rst_n),
    .in_vld  (app_wdf_wren & app_wdf_rdy),
    .in_dat  (app_wdf_data),
    .full    (wdf_full),
    .out_vld (wdf_out_vld),
    .out_dat (wdf_out_dat),
    .out_rdy (wdf_pop)
  );

  // Column bits below the burst and bits above the RAM depth do not select storage.
  logic addr_unused;
  assign addr_unused = ^{app_addr[ADDR_WIDTH-1:IW+3], app_addr[2:0]};

  // ---------------- in-order execution ----------------
  logic [2:0]    head_cmd;
  logic [IW-1:0] head_idx;
  logic          exec_wr, exec_rd, exec_ill;

  assign head_cmd = cmd_out_dat[CW-1 -: 3];
  assign head_idx = cmd_out_dat[IW-1:0];

  always_comb begin
    exec_wr  = 1'b0;
    exec_rd  = 1'b0;
    exec_ill = 1'b0;
    if (cmd_out_vld) begin
      case (head_cmd)
        CMD_WR:  exec_wr  = wdf_out_vld;  // a write without data stalls the whole queue
        CMD_RD:  exec_rd  = 1'b1;
        default: exec_ill = 1'b1;
      endcase
    end
  end

  assign cmd_pop = exec_wr | exec_rd | exec_ill;
  assign wdf_pop = exec_wr;

  // ---------------- backing RAM ----------------
  logic [BW-1:0] mem [2**IW];
  logic [BW-1:0] ram_rd_dat;

  // Read and write are both sampled at the execution edge, so a read always sees
  // every write that was ahead of it in the queue.
  always_ff @(posedge ddr_ui_clk) begin
    if (exec_wr) mem[head_idx] <= wdf_out_dat;
    if (exec_rd) ram_rd_dat    <= mem[head_idx];
  end

  // ---------------- read-return pipeline ----------------
  // rd_vld_q[0] marks the RAM output register; stages 1..RD_LATENCY carry data.
  logic [RD_LATENCY:0] rd_vld_q, rd_vld_d;
  logic [BW-1:0]       rd_dat_q [1:RD_LATENCY];
  logic [BW-1:0]       rd_dat_d [1:RD_LATENCY];

  always_comb begin
    rd_vld_d = {rd_vld_q[RD_LATENCY-1:0], exec_rd};
    rd_dat_d = rd_dat_q;
    // Stages only load on a valid beat, so app_rd_data holds the last burst between strobes.
    if (rd_vld_q[0]) rd_dat_d[1] = ram_rd_dat;
    for (int i = 2; i <= RD_LATENCY; i++) begin
      if (rd_vld_q[i-1]) rd_dat_d[i] = rd_dat_q[i-1];
    end
  end

  assign app_rd_data         = rd_dat_q[RD_LATENCY];
  assign app_rd_data_valid   = rd_vld_q[RD_LATENCY];
  assign init_calib_complete = calib_q;

  // ---------------- protocol error ----------------
  logic err_q, err_d;
  always_comb err_d = err_q | exec_ill | (app_wdf_wren ^ app_wdf_end);
  assign o_proto_err = err_q;

  always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
    if (!ddr_log_rst_n) begin
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
      rd_vld_q    <= '0;
      rd_dat_q    <= '{default: '0};
      err_q       <= 1'b0;
    end else begin
      calib_cnt_q <= calib_cnt_d;
      calib_q     <= calib_d;
      rd_vld_q    <= rd_vld_d;
      rd_dat_q    <= rd_dat_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_ddr_app_responder.sv
// tb_ddr_app_responder: randomized and directed stimulus against a queue-based reference.
// Latency: checks exact read latency on directed reads; ordering/data on every valid.
// Backpressure: driver holds each command/beat until the matching ready is seen.
module tb_ddr_app_responder;
  localparam int L   = 8;
  localparam int IW  = 10;
  localparam int CAL = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [511:0] app_wdf_data = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         init_calib_complete;
  logic         o_proto_err;

  always #5 clk = ~clk;

  ddr_app_responder dut (
    .ddr_ui_clk          (clk),
    .ddr_log_rst_n       (rst_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .init_calib_complete (init_calib_complete),
    .o_proto_err         (o_proto_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit [2:0] cmd; int idx; } mcmd_t;
  typedef struct { bit [511:0] d; bit known; } exp_t;
  bit [511:0] mem_m [int];
  mcmd_t      cmdq[$];
  bit [511:0] datq[$];
  exp_t       expq[$];

  // Commands retire strictly in acceptance order; the k-th write pairs with the k-th data beat.
  function automatic void resolve();
    while (cmdq.size() > 0) begin
      if (cmdq[0].cmd == 3'b000) begin
        if (datq.size() == 0) break;
        mem_m[cmdq[0].idx] = datq.pop_front();
      end else if (cmdq[0].cmd == 3'b001) begin
        exp_t e;
        e.known = mem_m.exists(cmdq[0].idx);
        e.d     = e.known ? mem_m[cmdq[0].idx] : '0;
        expq.push_back(e);
      end
      void'(cmdq.pop_front());
    end
  endfunction

  bit cmd_acc = 0, wdf_acc = 0;
  int valid_cnt = 0, vrun = 0, vrun_max = 0;

  // Compare process: observes handshakes and checks every read strobe.
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      valid_cnt++;
      vrun++;
      if (vrun > vrun_max) vrun_max = vrun;
    end else begin
      vrun = 0;
    end
    if (!rst_n) begin
      cmdq.delete();
      datq.delete();
      expq.delete();
      cmd_acc = 0;
      wdf_acc = 0;
      if (app_rd_data_valid) chk("valid_in_reset", 1, 0);
    end else begin
      if (app_rd_data_valid) begin
        if (expq.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          if (e.known) chk("rd_data", app_rd_data, e.d);
        end
      end
      cmd_acc = app_en & app_rdy;
      wdf_acc = app_wdf_wren & app_wdf_rdy;
      if (cmd_acc) begin
        mcmd_t m;
        m.cmd = app_cmd;
        m.idx = int'(app_addr[IW+2:3]);
        cmdq.push_back(m);
      end
      if (wdf_acc) datq.push_back(app_wdf_data);
      resolve();
    end
  end

  // ---------------- helpers (all start/end at posedge+1) ----------------
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [27:0] mkaddr(input int idx);
    logic [14:0] up;
    logic [2:0]  lo;
    up = 15'($urandom);
    lo = 3'($urandom);
    return {up, idx[9:0], lo};
  endfunction

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] addr, output int acc);
    acc = -1;
    app_en = 1'b1; app_cmd = c; app_addr = addr;
    for (int i = 0; i < 500 && acc < 0; i++) begin
      @(negedge clk);
      if (app_rdy) acc = cyc + 1;
      @(posedge clk); #1;
    end
    app_en = 1'b0;
    if (acc < 0) timeout_fail("cmd_accept");
  endtask

  task automatic send_data(input logic [511:0] d);
    bit done;
    done = 0;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (app_wdf_rdy) done = 1;
      @(posedge clk); #1;
    end
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    if (!done) timeout_fail("wdf_accept");
  endtask

  task automatic wr(input logic [27:0] addr, input logic [511:0] d);
    bit c_done, d_done;
    c_done = 0; d_done = 0;
    app_en = 1'b1; app_cmd = 3'b000; app_addr = addr;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d;
    for (int i = 0; i < 500 && !(c_done && d_done); i++) begin
      @(negedge clk);
      if (app_en && app_rdy) c_done = 1;
      if (app_wdf_wren && app_wdf_rdy) d_done = 1;
      @(posedge clk); #1;
      if (c_done) app_en = 1'b0;
      if (d_done) begin app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
    end
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    if (!(c_done && d_done)) timeout_fail("wr_accept");
  endtask

  task automatic wait_valid(output int c, output logic [511:0] d);
    c = -1; d = '0;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (app_rd_data_valid) begin c = cyc; d = app_rd_data; end
    end
    @(posedge clk); #1;
    if (c < 0) timeout_fail("rd_valid");
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (expq.size() == 0) && (cmdq.size() == 0);
    end
    repeat (3) @(posedge clk);
    #1;
    if (!ok) timeout_fail("quiesce");
  endtask

  task automatic chk_reset_state();
    chk("rst_app_rdy",     app_rdy, 0);
    chk("rst_app_wdf_rdy", app_wdf_rdy, 0);
    chk("rst_rd_data",     app_rd_data, 0);
    chk("rst_rd_valid",    app_rd_data_valid, 0);
    chk("rst_calib",       init_calib_complete, 0);
    chk("rst_proto_err",   o_proto_err, 0);
  endtask

  task automatic apply_reset(input bit detailed);
    bit ok;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;   // released between edges; the next posedge is edge 1
    if (detailed) begin
      for (int k = 1; k <= CAL; k++) begin
        @(posedge clk); #1;
        if (k == CAL - 1) begin
          chk("calib_at_99",  init_calib_complete, 0);
          chk("rdy_at_99",    app_rdy, 0);
          chk("wdfrdy_at_99", app_wdf_rdy, 0);
        end
        if (k == CAL) begin
          chk("calib_at_100", init_calib_complete, 1);
          chk("rdy_at_100",   app_rdy, 1);
        end
      end
    end else begin
      ok = 0;
      for (int k = 0; k < 300 && !ok; k++) begin
        @(posedge clk); #1;
        ok = init_calib_complete;
      end
      if (!ok) timeout_fail("recalib");
    end
  endtask

  // ---------------- test sequence ----------------
  localparam logic [7:0] PAT [4] = '{8'h3C, 8'hC3, 8'h5A, 8'h96};

  initial begin
    int acc, c, base;
    logic [511:0] d, a5;
    logic [7:0] p;

    a5 = {64{8'hA5}};
    apply_reset(1'b1);

    // Write with data, then read back: exact latency and literal data.
    wr(28'h40, a5);
    send_cmd(3'b001, 28'h40, acc);
    wait_valid(c, d);
    chk("rd_latency", c, acc + L + 1);
    chk("rd_A5", d, a5);

    // Preload bursts 0..31 with random data through aliased addresses.
    for (int i = 0; i < 32; i++) wr(mkaddr(i), rnd512());
    wait_quiet();

    // 16 back-to-back reads of distinct bursts.
    vrun_max = 0;
    for (int k = 0; k < 16; k++) begin
      bit ok;
      ok = 0;
      app_en = 1'b1; app_cmd = 3'b001; app_addr = mkaddr(k * 2);
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = app_rdy;
        @(posedge clk); #1;
      end
      if (!ok) timeout_fail("b2b_accept");
    end
    app_en = 1'b0;
    repeat (L + 6) @(posedge clk);
    #1;
    chk("b2b_run", vrun_max, 16);
    chk("b2b_pending", expq.size(), 0);

    // Four write commands without data fill the queue.
    for (int k = 0; k < 4; k++) send_cmd(3'b000, mkaddr(40 + k), acc);
    repeat (5) @(posedge clk);
    #1;
    chk("wr_block_rdy", app_rdy, 0);
    for (int k = 0; k < 4; k++) begin
      p = PAT[k];
      send_data({64{p}});
    end
    repeat (4) @(posedge clk);
    #1;
    chk("wr_drain_rdy", app_rdy, 1);
    send_cmd(3'b001, mkaddr(40), acc);
    wait_valid(c, d);
    p = PAT[0];
    chk("wr_block_rd40", d, {64{p}});
    for (int k = 1; k < 4; k++) send_cmd(3'b001, mkaddr(40 + k), acc);
    wait_quiet();

    // Randomized mix of reads, writes and independently-timed data.
    app_en = 1'b0; app_wdf_wren = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!app_en || cmd_acc) begin
        app_en   = ($urandom_range(0, 3) != 0);
        app_cmd  = 3'($urandom_range(0, 1));
        app_addr = mkaddr(int'($urandom_range(0, 31)));
      end
      if (!app_wdf_wren || wdf_acc) begin
        app_wdf_wren = ($urandom_range(0, 2) == 0);
        app_wdf_end  = app_wdf_wren;
        app_wdf_data = rnd512();
      end
      @(posedge clk); #1;
    end
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    for (int i = 0; i < 64 && cmdq.size() > 0; i++) send_data(rnd512());
    wait_quiet();
    chk("rand_drained", expq.size(), 0);

    // Reset with three reads in flight: they must never return.
    send_cmd(3'b001, mkaddr(0), acc);
    send_cmd(3'b001, mkaddr(2), acc);
    send_cmd(3'b001, mkaddr(4), acc);
    @(posedge clk); #1;
    base = valid_cnt;
    apply_reset(1'b0);
    chk("rst_dropped_reads", valid_cnt - base, 0);
    for (int k = 0; k < 6; k++) send_cmd(3'b001, mkaddr(k), acc);
    wait_quiet();
    chk("rst_readback_cnt", valid_cnt - base, 6);

    // Illegal command: no RAM write even with a data beat waiting.
    chk("err_clear", o_proto_err, 0);
    send_data(rnd512());
    send_cmd(3'b010, mkaddr(0), acc);
    repeat (2) @(posedge clk);
    #1;
    chk("err_illegal", o_proto_err, 1);
    send_cmd(3'b001, mkaddr(0), acc);
    wait_quiet();

    // wren without end sets the flag, which then stays set.
    apply_reset(1'b0);
    chk("err_after_rst", o_proto_err, 0);
    app_wdf_wren = 1'b1; app_wdf_end = 1'b0; app_wdf_data = rnd512();
    @(posedge clk); #1;
    app_wdf_wren = 1'b0;
    @(posedge clk); #1;
    chk("err_wren_end", o_proto_err, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("err_sticky", o_proto_err, 1);
    chk("final_pending", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
